hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage RV32 core. Consumes ID/EX hazard information, the EX branch resolution and the instruction/data memory busy flags. Produces the PC enable/redirect and the stall/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also keeps a redirect pending across fetch waits, because the IF/ID register gives its fetch-stall input priority over flush; it keeps stall/redirect performance counters as well.

---
 rtl/core_pkg.sv | 15 +
 rtl/load_use_detect.sv | 25 ++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants for the 5-stage RV32 pipeline.
// Holds the hazard controller FSM state encoding, XLEN and REG_ZERO.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IFW    = 2'd1,
    IFW_RD = 2'd2
  } hc_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between ID sources and EX load dest.
// Ports: id_rs1/id_rs2 + use flags, ex_rd, ex_mem_read in; hazard out.
module load_use_detect
  import core_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       hazard
);

  logic hit1;
  logic hit2;

  assign hit1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit2 = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is never really written, so a load to it cannot create a hazard
  assign hazard = ex_mem_read && (ex_rd != REG_ZERO)
                  && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: PC enable/redirect, pipeline stall/flush
// controls, pending redirect across fetch waits, stall/redirect counters.
// Ports: clk, rst (sync high); ID/EX hazard info, branch, im/dm stall in;
// pc_en, redirect, redirect_pc, stall/flush controls, stall_cnt, redir_cnt out.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             im_stall,
  input  logic             dm_stall,
  output logic             pc_en,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             stall_IF,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  hc_state_t       state;
  hc_state_t       state_d;
  logic            issued;
  logic            issued_d;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] tgt_d;
  logic            lu;

  load_use_detect u_lud (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hazard      (lu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      issued    <= 1'b0;
      tgt       <= '0;
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      state  <= state_d;
      issued <= issued_d;
      tgt    <= tgt_d;
      if (!pc_en)
        stall_cnt <= stall_cnt + 1'b1;
      if (redirect)
        redir_cnt <= redir_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d      = state;
    issued_d     = issued;
    tgt_d        = tgt;
    pc_en        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = ex_target;
    stall_IF     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;

    if (rst) begin
      redirect_pc = '0;
    end else if (dm_stall) begin
      // full freeze; FSM and pending target hold
      stall_IF     = 1'b1;
      if_id_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_stall = 1'b1;
    end else if (state == IFW_RD) begin
      id_ex_flush = 1'b1;
      if (im_stall) begin
        stall_IF = 1'b1;
      end else begin
        redirect    = 1'b1;
        redirect_pc = tgt;
        pc_en       = 1'b1;
        if_id_flush = 1'b1;
        issued_d    = 1'b0;
        state_d     = RUN;
      end
    end else if (im_stall) begin
      // RUN or IFW while fetch is pending
      stall_IF = 1'b1;
      if (ex_branch_taken) begin
        tgt_d       = ex_target;
        id_ex_flush = 1'b1;
        state_d     = IFW_RD;
      end else begin
        // held ID instr already went to ID/EX once; bubble repeats
        id_ex_flush = issued;
        issued_d    = 1'b1;
        state_d     = IFW;
      end
    end else begin
      // RUN rules, also used on the IFW exit cycle
      state_d  = RUN;
      issued_d = 1'b0;
      if (ex_branch_taken) begin
        redirect    = 1'b1;
        pc_en       = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
      if (issued)
        id_ex_flush = 1'b1;
    end
  end

endmodule
